conv_out_serializer_64: RTL and testbench

- Consumer end of the 64-channel convolution output bus.
- Captures the packed per-filter accumulators from a 64-filter RGB conv layer when a frame-valid strobe arrives.
- Applies ReLU, right-shift and saturation to quantize each accumulator to pixel width.
- Streams results one channel per beat over a valid/ready interface toward pooling or the next layer. Two capture banks (ping-pong) let a new window be captured while the previous one drains.

---
 rtl/conv_out_serializer_64_pkg.sv | 24 ++
 rtl/conv_out_serializer_64_relu_quantizer.sv | 26 ++
 rtl/conv_out_serializer_64.sv | 127 ++++++++++++
 tb/tb_conv_out_serializer_64.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_out_serializer_64_pkg.sv
// Shared constants, width helpers and drain FSM encoding for the conv output serializer.
package conv_out_serializer_64_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int NUM_CH         = 64;

  // Accumulator width carried on the conv bus for a given pixel width.
  function automatic int acc_width(input int dw);
    return 2 * dw + 6;
  endfunction

  // Channel index width; never narrower than one bit.
  function automatic int ch_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ACC_WIDTH    = acc_width(DEF_DATA_WIDTH);
  localparam int CH_IDX_WIDTH = ch_idx_width(NUM_CH);

  // Drain FSM states.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/conv_out_serializer_64_relu_quantizer.sv
// ReLU, arithmetic right shift and unsigned saturation of one accumulator to pixel width.
module conv_relu_quantizer
  import conv_out_serializer_64_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OUT_SHIFT  = 0,
  localparam int AW        = acc_width(DATA_WIDTH)
)(
  input  logic signed [AW-1:0]         acc,
  output logic        [DATA_WIDTH-1:0] q
);

  logic signed [AW-1:0] shifted;

  assign shifted = acc >>> OUT_SHIFT;

  // Negative clamps to zero; any set bit above the pixel field saturates to all-ones.
  always_comb begin
    q = shifted[DATA_WIDTH-1:0];
    if (acc[AW-1])
      q = '0;
    else if (|shifted[AW-1:DATA_WIDTH])
      q = '1;
  end

endmodule

// File: rtl/conv_out_serializer_64.sv
// Ping-pong capture of the packed conv accumulator bus, streamed out one quantized
// channel per beat over valid/ready. Bank occupancy is tracked by per-bank full flags.
module conv_out_serializer_64
  import conv_out_serializer_64_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = conv_out_serializer_64_pkg::NUM_CH,
  parameter int OUT_SHIFT  = 0,
  localparam int AW        = acc_width(DATA_WIDTH),
  localparam int CW        = ch_idx_width(NUM_CH)
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*AW-1:0]   conv_outs,
  input  logic                   conv_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [CW-1:0]          m_ch,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   drop_err
);

  logic [NUM_CH-1:0][AW-1:0] bank [2];
  logic [1:0]                full;
  logic [1:0]                full_set, full_clr;
  logic                      wr_ptr, rd_ptr;
  logic [0:0]                state;
  logic                      capture, accept, last_accept;
  logic                      src_bank;
  logic [CW-1:0]             src_ch;
  logic [AW-1:0]             src_acc;
  logic [DATA_WIDTH-1:0]     q;

  // Only registered state feeds in_ready, so a bank freeing this cycle can't rescue a strobe.
  assign in_ready    = ~(full[0] & full[1]);
  assign capture     = conv_valid & in_ready;
  assign accept      = m_valid & m_ready;
  assign last_accept = (state == ST_SEND) & accept & m_last;

  // Pick the accumulator for the beat loaded at the next edge: ch0 of the read bank when
  // starting, the next channel mid-frame, or ch0 of the other bank after the last beat.
  always_comb begin
    src_bank = rd_ptr;
    src_ch   = '0;
    if (state == ST_SEND) begin
      if (m_last) src_bank = ~rd_ptr;
      else        src_ch   = m_ch + 1'b1;
    end
  end

  assign src_acc = bank[src_bank][src_ch];

  conv_relu_quantizer #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_SHIFT  (OUT_SHIFT)
  ) u_quant (
    .acc (src_acc),
    .q   (q)
  );

  // Full flag set/clear masks; set and clear never target the same bank.
  always_comb begin
    full_set = '0;
    full_clr = '0;
    if (capture)     full_set[wr_ptr] = 1'b1;
    if (last_accept) full_clr[rd_ptr] = 1'b1;
  end

  // Bank storage; contents are only meaningful while the matching full flag is set.
  always_ff @(posedge clk) begin
    if (capture) bank[wr_ptr] <= conv_outs;
  end

  // Bank bookkeeping, drop flag and drain FSM with output beat registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full     <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      state    <= ST_IDLE;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_data   <= '0;
      m_ch     <= '0;
      drop_err <= 1'b0;
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (capture)                 wr_ptr   <= ~wr_ptr;
      if (conv_valid && !in_ready) drop_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (full[rd_ptr]) begin
            state   <= ST_SEND;
            m_valid <= 1'b1;
            m_ch    <= '0;
            m_last  <= (NUM_CH == 1);
            m_data  <= q;
          end
        end
        ST_SEND: begin
          if (accept) begin
            if (!m_last) begin
              m_ch   <= m_ch + 1'b1;
              m_last <= (m_ch == CW'(NUM_CH - 2));
              m_data <= q;
            end else begin
              rd_ptr <= ~rd_ptr;
              if (full[~rd_ptr]) begin
                m_ch   <= '0;
                m_last <= (NUM_CH == 1);
                m_data <= q;
              end else begin
                state   <= ST_IDLE;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_out_serializer_64.sv
// Directed bench for conv_out_serializer_64. Three instances with OUT_SHIFT 0/2/3 share
// all inputs and so run in lockstep; each test checks the instance whose shift it needs.
// Latency: a strobe sampled at edge t is captured there; the drain FSM sees the bank full
// at edge t+1 and presents ch0, so m_valid is visible one cycle after the capture edge.
module tb_conv_out_serializer_64;
  import conv_out_serializer_64_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic conv_valid;
  logic m_ready;
  logic [NUM_CH-1:0][ACC_WIDTH-1:0] frame;

  logic [2:0]              in_ready, m_valid, m_last, drop_err;
  logic [7:0]              m_data [3];
  logic [CH_IDX_WIDTH-1:0] m_ch   [3];

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_v [64];

  // Hand-computed quantizer results for ch0..4 of the quantization frame per shift.
  logic [7:0] q_s0 [5] = '{8'd0, 8'd255, 8'd255, 8'd0, 8'd80};
  logic [7:0] q_s2 [5] = '{8'd0, 8'd250, 8'd63,  8'd0, 8'd20};
  logic [7:0] q_s3 [5] = '{8'd0, 8'd125, 8'd31,  8'd0, 8'd10};

  always #5 clk = ~clk;

  conv_out_serializer_64 #(.OUT_SHIFT(0)) u_s0 (
    .clk(clk), .rst(rst), .conv_outs(frame), .conv_valid(conv_valid), .in_ready(in_ready[0]),
    .m_data(m_data[0]), .m_ch(m_ch[0]), .m_last(m_last[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready), .drop_err(drop_err[0]));
  conv_out_serializer_64 #(.OUT_SHIFT(2)) u_s2 (
    .clk(clk), .rst(rst), .conv_outs(frame), .conv_valid(conv_valid), .in_ready(in_ready[1]),
    .m_data(m_data[1]), .m_ch(m_ch[1]), .m_last(m_last[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready), .drop_err(drop_err[1]));
  conv_out_serializer_64 #(.OUT_SHIFT(3)) u_s3 (
    .clk(clk), .rst(rst), .conv_outs(frame), .conv_valid(conv_valid), .in_ready(in_ready[2]),
    .m_data(m_data[2]), .m_ch(m_ch[2]), .m_last(m_last[2]), .m_valid(m_valid[2]),
    .m_ready(m_ready), .drop_err(drop_err[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    conv_valid = 1'b1;
    tick();
    conv_valid = 1'b0;
  endtask

  // Drain one frame from instance k against exp_v. stall alternates m_ready 1,0,...
  // imm requires the first beat already valid; strobe_at strobes frame on that beat's accept.
  task automatic drain(input string tag, input int k, input bit stall, input bit imm,
                       input int strobe_at, input bit want_ready);
    int beat = 0;
    int cyc = 0;
    bit started = 1'b0;
    if (imm) chk({tag, "_imm"}, m_valid[k], 1);
    while (beat < 64 && cyc < 2000) begin
      m_ready = stall ? (cyc % 2 == 0) : 1'b1;
      if (started) chk({tag, "_bubble"}, m_valid[k], 1);
      if (m_valid[k]) begin
        started = 1'b1;
        chk({tag, "_ch"},   m_ch[k],   beat);
        chk({tag, "_dat"},  m_data[k], exp_v[beat]);
        chk({tag, "_last"}, m_last[k], (beat == 63));
        if (want_ready) chk({tag, "_inrdy"}, in_ready[k], 1);
        if (m_ready) begin
          if (beat == strobe_at) begin
            chk({tag, "_strobe_rdy"}, in_ready[k], 1);
            conv_valid = 1'b1;
          end
          beat++;
        end
      end
      tick();
      conv_valid = 1'b0;
      cyc++;
    end
    chk({tag, "_beats"}, beat, 64);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; conv_valid = 1'b0; m_ready = 1'b0; frame = '0;
    tick(); tick();
    chk("rst_valid", m_valid[0], 0);
    chk("rst_last",  m_last[0],  0);
    chk("rst_data",  m_data[0],  0);
    chk("rst_ch",    m_ch[0],    0);
    chk("rst_drop",  drop_err[0], 0);
    rst = 1'b1;
    tick();
    chk("rst_inrdy", in_ready[0], 1);

    // Single frame through the shift-2 instance: ch i = 4*i -> i.
    for (int i = 0; i < 64; i++) begin
      frame[i] = ACC_WIDTH'(4 * i);
      exp_v[i] = 8'(i);
    end
    m_ready = 1'b1;
    strobe();
    chk("lat_cap", m_valid[1], 0);
    tick();
    chk("lat_out", m_valid[1], 1);
    drain("single", 1, 1'b0, 1'b1, -1, 1'b1);
    chk("single_end", m_valid[1], 0);

    // Quantization corners, checked across all three shifts.
    frame = '0;
    frame[0] = ACC_WIDTH'(-5);
    frame[1] = ACC_WIDTH'(1000);
    frame[2] = ACC_WIDTH'(255);
    frame[3] = ACC_WIDTH'(-2097152);
    frame[4] = ACC_WIDTH'(80);
    strobe();
    tick();
    for (int c = 0; c < 64; c++) begin
      if (c < 5) begin
        chk($sformatf("q_s0_ch%0d", c), m_data[0], q_s0[c]);
        chk($sformatf("q_s2_ch%0d", c), m_data[1], q_s2[c]);
        chk($sformatf("q_s3_ch%0d", c), m_data[2], q_s3[c]);
      end
      chk("q_ch", m_ch[0], c);
      tick();
    end
    chk("q_end", m_valid[0], 0);

    // Backpressure on ready pattern 1,0,1,0: ch i = 3*i+7.
    for (int i = 0; i < 64; i++) begin
      frame[i] = ACC_WIDTH'(3 * i + 7);
      exp_v[i] = 8'(3 * i + 7);
    end
    strobe();
    drain("bp", 0, 1'b1, 1'b0, -1, 1'b0);
    m_ready = 1'b1;
    tick();
    chk("bp_end", m_valid[0], 0);

    // Overflow: A and B fill both banks under stall, C is dropped.
    m_ready = 1'b0;
    for (int i = 0; i < 64; i++) frame[i] = ACC_WIDTH'(1);
    strobe();
    for (int i = 0; i < 64; i++) frame[i] = ACC_WIDTH'(2);
    strobe();
    chk("ovf_inrdy", in_ready[0], 0);
    chk("ovf_nodrop", drop_err[0], 0);
    for (int i = 0; i < 64; i++) frame[i] = ACC_WIDTH'(3);
    strobe();
    chk("ovf_drop", drop_err[0], 1);
    chk("ovf_inrdy2", in_ready[0], 0);
    for (int i = 0; i < 64; i++) exp_v[i] = 8'd1;
    drain("ovfA", 0, 1'b0, 1'b1, -1, 1'b0);
    for (int i = 0; i < 64; i++) exp_v[i] = 8'd2;
    drain("ovfB", 0, 1'b0, 1'b1, -1, 1'b0);
    chk("ovf_noC", m_valid[0], 0);
    tick();
    chk("ovf_noC2", m_valid[0], 0);
    chk("ovf_sticky", drop_err[0], 1);

    // Reset in the middle of a drain at beat 10.
    for (int i = 0; i < 64; i++) begin
      frame[i] = ACC_WIDTH'(i);
      exp_v[i] = 8'(i);
    end
    m_ready = 1'b1;
    strobe();
    begin
      int n = 0;
      while (!(m_valid[0] && m_ch[0] == 10) && n < 200) begin
        tick();
        n++;
      end
      chk("mrst_reach10", (m_valid[0] && m_ch[0] == 10), 1);
    end
    rst = 1'b0;
    tick();
    chk("mrst_valid", m_valid[0], 0);
    chk("mrst_inrdy", in_ready[0], 1);
    chk("mrst_drop",  drop_err[0], 0);
    rst = 1'b1;
    tick();
    chk("mrst_idle", m_valid[0], 0);
    strobe();
    tick();
    drain("mrst", 0, 1'b0, 1'b1, -1, 1'b0);

    // Concurrent capture of B on the cycle A's ch20 is accepted.
    strobe();
    tick();
    for (int i = 0; i < 64; i++) frame[i] = ACC_WIDTH'(2 * i + 1);
    drain("concA", 0, 1'b0, 1'b1, 20, 1'b0);
    for (int i = 0; i < 64; i++) exp_v[i] = 8'(2 * i + 1);
    drain("concB", 0, 1'b0, 1'b1, -1, 1'b0);
    chk("conc_end", m_valid[0], 0);
    chk("conc_nodrop", drop_err[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
